// File: rtl/cypher_detector_param.sv
// Cypher detector: scans a valid/ready symbol stream for a loadable KEY_LEN-symbol key,
// counts full matches (saturating) and keeps a running symbol sum compared against a threshold.
module cypher_detector_param #(
  parameter int DATA_W  = 8,
  parameter int KEY_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int SUM_W   = 16,
  localparam int IDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              key_wr,
  input  logic [IDX_W-1:0]  key_idx,
  input  logic [DATA_W-1:0] key_data,
  input  logic [SUM_W-1:0]  threshold,
  output logic              busy,
  output logic              detect,
  output logic [CNT_W-1:0]  match_count,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_ovf,
  output logic              over_threshold,
  output logic              done
);

  // Key storage is padded to a power of two so r_idx can index it without width mismatch.
  localparam int KEY_SLOTS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DECIDE = 3'd2,
    S_MATCH  = 3'd3,
    S_MISS   = 3'd4,
    S_SUM    = 3'd5,
    S_COMP   = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_key [0:KEY_SLOTS-1];
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_sym;
  logic              r_last;
  logic              r_detect;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [SUM_W-1:0]  r_sum;
  logic              r_ovf;
  logic              r_over;

  logic              w_hit;
  logic              w_first;
  logic              w_last_idx;
  logic              w_key_ok;
  logic [SUM_W:0]    w_sum_ext;

  assign w_hit      = (r_sym == r_key[r_idx]);
  assign w_first    = (r_sym == r_key[0]);
  assign w_last_idx = (r_idx == IDX_W'(KEY_LEN - 1));
  assign w_key_ok   = (int'(key_idx) < KEY_LEN);
  assign w_sum_ext  = {1'b0, r_sum} + (SUM_W + 1)'(r_sym);

  assign in_ready       = (r_state == S_READ);
  assign busy           = (r_state != S_IDLE);
  assign detect         = r_detect;
  assign done           = r_done;
  assign match_count    = r_cnt;
  assign sum_out        = r_sum;
  assign sum_ovf        = r_ovf;
  assign over_threshold = r_over;

  // Key slots are writable only while idle; out-of-range slot indices are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KEY_SLOTS; i++) begin
        r_key[i] <= '0;
      end
    end else if (key_wr && (r_state == S_IDLE) && w_key_ok) begin
      r_key[key_idx] <= key_data;
    end
  end

  // Control FSM with its datapath registers; detect and done are high for exactly one state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_sym    <= '0;
      r_last   <= 1'b0;
      r_detect <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_detect <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_over  <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (in_valid) begin
            r_sym   <= in_data;
            r_last  <= in_last;
            r_state <= S_DECIDE;
          end else begin
            r_state <= S_READ;
          end
        end
        S_DECIDE: begin
          if (w_hit) begin
            r_state  <= S_MATCH;
            r_detect <= w_last_idx;
          end else begin
            r_state  <= S_MISS;
          end
        end
        S_MATCH: begin
          if (w_last_idx) begin
            r_idx <= '0;
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end else begin
              r_cnt <= r_cnt;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
          r_state <= S_SUM;
        end
        S_MISS: begin
          // Restart rule: a mismatching symbol may still open a new attempt at slot 0.
          if ((KEY_LEN > 1) && w_first) begin
            r_idx <= IDX_W'(1);
          end else begin
            r_idx <= '0;
          end
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_sum <= w_sum_ext[SUM_W-1:0];
          if (w_sum_ext[SUM_W]) begin
            r_ovf <= 1'b1;
          end else begin
            r_ovf <= r_ovf;
          end
          r_state <= S_COMP;
        end
        S_COMP: begin
          r_over <= (r_sum >= threshold);
          if (r_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_READ;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
